// File: rtl/elastic_pipeline_stage.sv
// Multi-lane elastic pipeline register: DEPTH-group buffer with a valid/ready handshake,
// a full clear, and a selective recovery flush driven by ActiveList age.

module eps_lane_age #(
  parameter int AW = 6
) (
  input  logic [AW-1:0] i_head,
  input  logic [AW-1:0] i_rec,
  input  logic [AW-1:0] i_ptr,
  output logic          o_squash
);
  logic [AW-1:0] w_age_p, w_age_r;

  // Ages are taken relative to the ActiveList head so the compare survives pointer wrap.
  assign w_age_p  = i_ptr - i_head;
  assign w_age_r  = i_rec - i_head;
  assign o_squash = (w_age_p > w_age_r);
endmodule

module elastic_pipeline_stage #(
  parameter int LANE_NUM      = 2,
  parameter int PAYLOAD_WIDTH = 64,
  parameter int DEPTH         = 2,
  parameter int AL_PTR_WIDTH  = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              recover,
  input  logic [AL_PTR_WIDTH-1:0]           alHeadPtr,
  input  logic [AL_PTR_WIDTH-1:0]           recoverPtr,
  input  logic [LANE_NUM-1:0]               inValid,
  input  logic [LANE_NUM*AL_PTR_WIDTH-1:0]  inAlPtr,
  input  logic [LANE_NUM*PAYLOAD_WIDTH-1:0] inData,
  output logic                              inReady,
  output logic [LANE_NUM-1:0]               outValid,
  output logic [LANE_NUM*AL_PTR_WIDTH-1:0]  outAlPtr,
  output logic [LANE_NUM*PAYLOAD_WIDTH-1:0] outData,
  input  logic                              outReady,
  output logic [$clog2(DEPTH+1)-1:0]        occupancy
);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][LANE_NUM-1:0]                    r_vld;
  logic [DEPTH-1:0][LANE_NUM-1:0][AL_PTR_WIDTH-1:0]  r_ptr;
  logic [DEPTH-1:0][LANE_NUM-1:0][PAYLOAD_WIDTH-1:0] r_data;
  logic [PTR_W-1:0] r_rd, r_wr;
  logic [OCC_W-1:0] r_occ;

  logic [LANE_NUM-1:0][AL_PTR_WIDTH-1:0] w_in_ptr;
  logic [DEPTH-1:0][LANE_NUM-1:0]        w_sq_st;
  logic [LANE_NUM-1:0]                   w_sq_in, w_in_vld, w_head_vld;
  logic                                  w_occ_nz, w_push, w_pop;

  assign w_in_ptr = inAlPtr;

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    for (genvar l = 0; l < LANE_NUM; l++) begin : g_lane
      eps_lane_age #(.AW(AL_PTR_WIDTH)) u_age (
        .i_head(alHeadPtr), .i_rec(recoverPtr), .i_ptr(r_ptr[e][l]), .o_squash(w_sq_st[e][l])
      );
    end
  end

  for (genvar l = 0; l < LANE_NUM; l++) begin : g_in
    eps_lane_age #(.AW(AL_PTR_WIDTH)) u_age (
      .i_head(alHeadPtr), .i_rec(recoverPtr), .i_ptr(w_in_ptr[l]), .o_squash(w_sq_in[l])
    );
  end

  assign w_occ_nz   = (r_occ != '0);
  assign w_head_vld = r_vld[r_rd];
  assign w_in_vld   = recover ? (inValid & ~w_sq_in) : inValid;
  assign inReady    = (r_occ < OCC_W'(DEPTH));
  assign w_push     = (|w_in_vld) && inReady && !clear;
  // Squashed heads drain on their own so they never stall the stage or show as valid.
  assign w_pop      = w_occ_nz && (outReady || (w_head_vld == '0)) && !clear;

  assign outValid  = w_occ_nz ? w_head_vld : '0;
  assign outAlPtr  = r_ptr[r_rd];
  assign outData   = r_data[r_rd];
  assign occupancy = r_occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
      r_rd  <= '0;
      r_wr  <= '0;
      r_vld <= '0;
    end else if (clear) begin
      r_occ <= '0;
      r_rd  <= '0;
      r_wr  <= '0;
      r_vld <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == PTR_W'(DEPTH-1)) ? '0 : r_wr + 1'b1;
      if (w_pop)  r_rd <= (r_rd == PTR_W'(DEPTH-1)) ? '0 : r_rd + 1'b1;
      if (w_push && !w_pop)      r_occ <= r_occ + 1'b1;
      else if (!w_push && w_pop) r_occ <= r_occ - 1'b1;
      for (int e = 0; e < DEPTH; e++)
        if (recover) r_vld[e] <= r_vld[e] & ~w_sq_st[e];
      if (w_push) r_vld[r_wr] <= w_in_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ptr[r_wr]  <= w_in_ptr;
      r_data[r_wr] <= inData;
    end
  end
endmodule

// File: tb/tb_elastic_pipeline_stage.sv
// Directed bench for elastic_pipeline_stage: expected groups go into a scoreboard queue,
// a negedge monitor checks every accepted output group; direct checks cover timing/occupancy.
module tb_elastic_pipeline_stage;
  logic         clk = 0, rst = 1, clear = 0, recover = 0, outReady = 0;
  logic [5:0]   alHeadPtr = 0, recoverPtr = 0;
  logic [1:0]   inValid = 0, outValid;
  logic [11:0]  inAlPtr = 0, outAlPtr;
  logic [127:0] inData = 0, outData;
  logic         inReady;
  logic [1:0]   occupancy;

  typedef struct { logic [1:0] v; logic [11:0] p; logic [127:0] d; } exp_t;
  exp_t q[$];
  int n_vec = 0, n_err = 0;

  elastic_pipeline_stage dut (
    .clk(clk), .rst(rst), .clear(clear), .recover(recover), .alHeadPtr(alHeadPtr),
    .recoverPtr(recoverPtr), .inValid(inValid), .inAlPtr(inAlPtr), .inData(inData),
    .inReady(inReady), .outValid(outValid), .outAlPtr(outAlPtr), .outData(outData),
    .outReady(outReady), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] dat(input logic [5:0] p);
    return 64'hC0DE_5A5A_0000_0000 | {58'd0, p};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic put(input logic [1:0] v, input logic [5:0] p0, input logic [5:0] p1);
    inValid = v;
    inAlPtr = {p1, p0};
    inData  = {dat(p1), dat(p0)};
  endtask

  task automatic expect_grp(input logic [1:0] v, input logic [5:0] p0, input logic [5:0] p1);
    exp_t e;
    e.v = v; e.p = {p1, p0}; e.d = {dat(p1), dat(p0)};
    q.push_back(e);
  endtask

  // Scoreboard monitor: one compare per group the downstream accepts.
  always @(negedge clk) begin
    if (!rst && (|outValid) && outReady) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got v=%b ptr=%h, expected no group", outValid, outAlPtr);
      end else begin
        exp_t e;
        logic ok;
        e  = q.pop_front();
        ok = (outValid === e.v);
        for (int l = 0; l < 2; l++)
          if (e.v[l])
            ok = ok && (outAlPtr[l*6 +: 6] === e.p[l*6 +: 6]) && (outData[l*64 +: 64] === e.d[l*64 +: 64]);
        if (!ok) begin
          n_err++;
          $display("FAIL sb_group: got v=%b ptr=%h, expected v=%b ptr=%h", outValid, outAlPtr, e.v, e.p);
        end
      end
    end
  end

  // A push offered while full must never raise occupancy.
  always @(posedge clk) begin
    logic full_push;
    logic [1:0] occ_b;
    full_push = !rst && (|inValid) && !inReady;
    occ_b     = occupancy;
    #1;
    if (full_push) begin
      n_vec++;
      if (occupancy > occ_b) begin
        n_err++;
        $display("FAIL full_write: got occ %0d, expected <= %0d", occupancy, occ_b);
      end
    end
  end

  initial begin
    #1;
    chk("rst_occ", occupancy, 0);
    chk("rst_rdy", inReady, 1);
    chk("rst_ov", outValid, 0);
    step(); rst = 0;

    // 1: single group, one-cycle latency, then drained
    put(2'b11, 3, 4); outReady = 1; expect_grp(2'b11, 3, 4);
    step(); put(0, 0, 0);
    chk("t1_ov", outValid, 2'b11);
    chk("t1_ptr", outAlPtr, {6'd4, 6'd3});
    step();
    chk("t1_occ", occupancy, 0);
    outReady = 0;

    // 2: back-pressure, third group refused, in-order drain
    put(2'b11, 8, 9); expect_grp(2'b11, 8, 9);
    step(); chk("t2_occ1", occupancy, 1); chk("t2_rdy1", inReady, 1);
    put(2'b11, 10, 11); expect_grp(2'b11, 10, 11);
    step(); chk("t2_occ2", occupancy, 2); chk("t2_rdy2", inReady, 0);
    put(2'b11, 12, 13);
    step(); chk("t2_occ3", occupancy, 2);
    put(0, 0, 0); outReady = 1;
    step(); chk("t2_drain1", occupancy, 1);
    step(); chk("t2_drain0", occupancy, 0);
    outReady = 0;

    // 3: wrap-around recovery, second group squashed and auto-popped
    alHeadPtr = 60;
    put(2'b11, 62, 63); expect_grp(2'b11, 62, 63);
    step(); put(2'b11, 0, 1);
    step(); put(0, 0, 0);
    chk("t3_occ_pre", occupancy, 2);
    recover = 1; recoverPtr = 63;
    step(); recover = 0;
    chk("t3_occ_post", occupancy, 2);
    chk("t3_ov_keep", outValid, 2'b11);
    outReady = 1;
    step(); outReady = 0;
    chk("t3_occ_sq", occupancy, 1);
    chk("t3_ov_sq", outValid, 2'b00);
    step();
    chk("t3_autopop", occupancy, 0);

    // 4: incoming lane masked by a same-cycle recover
    alHeadPtr = 0; recover = 1; recoverPtr = 4;
    put(2'b11, 4, 5); expect_grp(2'b01, 4, 5);
    step(); recover = 0; put(0, 0, 0);
    chk("t4_ov", outValid, 2'b01);
    chk("t4_ptr0", outAlPtr[5:0], 4);
    outReady = 1;
    step(); outReady = 0;
    chk("t4_occ", occupancy, 0);

    // 5: clear beats recover, push and pop
    put(2'b11, 20, 21); expect_grp(2'b11, 20, 21);
    step(); put(2'b11, 22, 23); expect_grp(2'b11, 22, 23);
    step(); chk("t5_full", occupancy, 2);
    clear = 1; recover = 1; recoverPtr = 63; outReady = 1; put(2'b11, 24, 25);
    step(); clear = 0; recover = 0; outReady = 0; put(0, 0, 0);
    q.delete();
    chk("t5_occ", occupancy, 0);
    chk("t5_ov", outValid, 0);
    chk("t5_rdy", inReady, 1);
    step(); chk("t5_occ_hold", occupancy, 0);

    // 6: asynchronous reset while full
    put(2'b11, 30, 31);
    step(); put(2'b11, 32, 33);
    step(); put(0, 0, 0);
    chk("t6_full", occupancy, 2);
    #2 rst = 1;
    #1;
    chk("t6_ov", outValid, 0);
    chk("t6_occ", occupancy, 0);
    chk("t6_rdy", inReady, 1);
    step(); rst = 0;
    put(2'b11, 40, 41); expect_grp(2'b11, 40, 41);
    step(); put(0, 0, 0);
    chk("t6_ov_after", outValid, 2'b11);
    chk("t6_ptr_after", outAlPtr, {6'd41, 6'd40});
    outReady = 1;
    step(); outReady = 0;
    chk("t6_occ_after", occupancy, 0);

    step();
    chk("sb_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
